// File: rtl/can_pkg.sv
// Shared types and constants for the CAN CRC-15 frame checker.
package can_pkg;

   localparam int          CRC_W    = 15;
   localparam int          BYTE_W   = 8;
   localparam logic [14:0] CRC_INIT = 15'h0000;

   // Frame-receive phases: data payload, then two CRC bytes (high first), then verdict.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_CRC_HI = 3'd2,
      ST_CRC_LO = 3'd3,
      ST_REPORT = 3'd4
   } state_e;

endpackage

// File: rtl/crc15_byte_update.sv
// Byte-parallel CRC-15 update: folds one data byte into the running remainder.
module crc15_byte_update
   import can_pkg::*;
(
   input  logic [BYTE_W-1:0] d,
   input  logic [CRC_W-1:0]  c,
   output logic [CRC_W-1:0]  next
);

   // Fixed XOR network; c14 is the feedback bit into the polynomial taps.
   always_comb begin
      next[0]  = d[0] ^ c[14];
      next[1]  = d[1] ^ c[0];
      next[2]  = d[2] ^ c[1];
      next[3]  = d[3] ^ c[2] ^ c[14];
      next[4]  = d[4] ^ c[3] ^ c[13];
      next[5]  = d[5] ^ c[4] ^ c[12];
      next[6]  = d[6] ^ c[5];
      next[7]  = d[7] ^ c[6];
      next[8]  = c[7];
      next[9]  = c[8];
      next[10] = c[9]  ^ c[14];
      next[11] = c[10];
      next[12] = c[11] ^ c[14];
      next[13] = c[12] ^ c[14];
      next[14] = c[13] ^ c[14];
   end

endmodule

// File: rtl/can_crc_checker.sv
// Receives a CAN-style frame byte stream (data, CRC high, CRC low), computes
// CRC-15 over the data and reports match / format / length verdicts.
module can_crc_checker
   import can_pkg::*;
#(
   parameter int MAX_BYTES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              busy,
   output logic              done,
   output logic              crc_ok,
   output logic              fmt_err,
   output logic              len_err,
   output logic [CRC_W-1:0]  crc_calc,
   output logic [7:0]        byte_cnt
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_BYTES);

   state_e           state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             fmt_q, fmt_d;
   logic             len_q, len_d;
   logic             ok_q, ok_d;
   logic [6:0]       rx_hi_q, rx_hi_d;

   logic [CRC_W-1:0] crc_nxt;
   logic             acc;

   crc15_byte_update u_crc (
      .d    (byte_data),
      .c    (crc_q),
      .next (crc_nxt)
   );

   assign acc = byte_valid & byte_ready;

   // Handshake/status decode straight from the phase register.
   always_comb begin
      byte_ready = (state_q == ST_DATA) || (state_q == ST_CRC_HI) || (state_q == ST_CRC_LO);
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_REPORT);
   end

   // Next-state and verdict datapath; start wins over any byte presented the same cycle.
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      cnt_d   = cnt_q;
      fmt_d   = fmt_q;
      len_d   = len_q;
      ok_d    = ok_q;
      rx_hi_d = rx_hi_q;
      if (start) begin
         state_d = ST_DATA;
         crc_d   = CRC_INIT;
         cnt_d   = 8'd0;
         fmt_d   = 1'b0;
         len_d   = 1'b0;
         ok_d    = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
               if (acc) begin
                  crc_d = crc_nxt;
                  cnt_d = cnt_q + 8'd1;
                  if (byte_last) begin
                     state_d = ST_CRC_HI;
                  end else if (cnt_q + 8'd1 == MAX_CNT) begin
                     // Payload filled without an end marker: give up on this frame.
                     len_d   = 1'b1;
                     ok_d    = 1'b0;
                     state_d = ST_REPORT;
                  end
               end
            end
            ST_CRC_HI: begin
               if (acc) begin
                  rx_hi_d = byte_data[6:0];
                  if (byte_data[7]) fmt_d = 1'b1;
                  state_d = ST_CRC_LO;
               end
            end
            ST_CRC_LO: begin
               if (acc) begin
                  // Verdict is registered here so it is already valid while done is high.
                  ok_d    = ({rx_hi_q, byte_data} == crc_q) && !fmt_q && !len_q;
                  state_d = ST_REPORT;
               end
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         crc_q   <= CRC_INIT;
         cnt_q   <= 8'd0;
         fmt_q   <= 1'b0;
         len_q   <= 1'b0;
         ok_q    <= 1'b0;
         rx_hi_q <= 7'd0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         cnt_q   <= cnt_d;
         fmt_q   <= fmt_d;
         len_q   <= len_d;
         ok_q    <= ok_d;
         rx_hi_q <= rx_hi_d;
      end
   end

   assign crc_ok   = ok_q;
   assign fmt_err  = fmt_q;
   assign len_err  = len_q;
   assign crc_calc = crc_q;
   assign byte_cnt = cnt_q;

endmodule

// File: doc/can_crc_checker.md
CAN_CRC_CHECKER -- requirements
Module: can_crc_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-002 The block SHALL expose parameter MAX_BYTES, default 16, meaning the maximum number of data bytes per frame (range 1..255).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a new frame.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  received byte.
REQ-008 byte_last  input  1  qualifies byte_valid; marks the final data byte.
REQ-009 byte_ready  output  1  block accepts a byte this cycle.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse; verdict outputs are valid.
REQ-012 crc_ok  output  1  computed CRC equals received CRC, with no format or length error.
REQ-013 fmt_err  output  1  bit 7 of the received CRC high byte was 1.
REQ-014 len_err  output  1  data exceeded MAX_BYTES without byte_last.
REQ-015 crc_calc  output  15  running/final computed CRC.
REQ-016 byte_cnt  output  8  count of data bytes accepted in the current frame.

Function
REQ-017 States SHALL be IDLE, DATA, CRC_HI, CRC_LO and REPORT.
REQ-018 A byte SHALL be accepted only in a cycle where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 in DATA, CRC_HI and CRC_LO, and 0 in IDLE and REPORT.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 In IDLE, start=1 SHALL clear crc_calc, byte_cnt, fmt_err and len_err, and move to DATA.
REQ-022 An accepted byte in DATA SHALL update crc_calc <= U(byte_data, crc_calc) and increment byte_cnt.
  - Move to CRC_HI if byte_last=1; otherwise stay in DATA.
REQ-023 The update function U(d,c) SHALL be:
  - n0=d0^c14, n1=d1^c0, n2=d2^c1, n3=d3^c2^c14, n4=d4^c3^c13
  - n5=d5^c4^c12, n6=d6^c5, n7=d7^c6, n8=c7, n9=c8
  - n10=c9^c14, n11=c10, n12=c11^c14, n13=c12^c14, n14=c13^c14
REQ-024 An accepted byte in CRC_HI SHALL latch rx_hi[6:0]=byte_data[6:0], set fmt_err if byte_data[7]=1, and move to CRC_LO.
  - crc_calc SHALL NOT be updated.
REQ-025 An accepted byte in CRC_LO SHALL latch rx_lo and move to REPORT.
REQ-026 In REPORT, done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
  - Latency from CRC_LO acceptance to done is 1 cycle.
REQ-027 crc_ok SHALL be set in REPORT to ({rx_hi,rx_lo}==crc_calc) && !fmt_err && !len_err.
  - crc_ok, fmt_err, len_err, crc_calc and byte_cnt SHALL hold until the next start or rst.
REQ-028 Length overrun: if the byte that makes byte_cnt equal MAX_BYTES is accepted with byte_last=0, the block SHALL set len_err and go to REPORT.
  - done then pulses with crc_ok=0.
REQ-029 start=1 while busy SHALL abort the frame with no done pulse, clear the same state as REQ-021, and enter DATA next cycle.
  - Any byte presented in that cycle is ignored.
REQ-030 byte_valid while in IDLE or REPORT SHALL be ignored, with no state change.
REQ-031 byte_last=1 in CRC_HI or CRC_LO SHALL be ignored.
REQ-032 byte_cnt SHALL never wrap; MAX_BYTES<=255 guarantees this.

Reset
REQ-033 rst=1 SHALL force IDLE on the next edge and has priority over start.
REQ-034 On reset: done=0, crc_ok=0, fmt_err=0, len_err=0, busy=0, byte_ready=0, crc_calc=15'h0000, byte_cnt=0.
REQ-035 Reset mid-frame SHALL discard the frame with no done pulse.

Structure
REQ-036 A shared package can_pkg SHALL hold the state enum type, CRC_W=15, CRC_INIT=15'h0000 and a byte-width constant.
REQ-037 The update equations SHALL live in one combinational sub-module, crc15_byte_update (d[7:0], c[14:0] -> next[14:0]), instantiated once.

Verification
REQ-038 The bench SHALL cover these directed scenarios:
  - start; data 0x01 (last); CRC 0x00, 0x01 -> done one cycle after the last CRC byte, crc_ok=1, crc_calc=0x0001, byte_cnt=1.
  - start; data 0xFF, 0x00 (last); CRC 0x01, 0xFE -> crc_ok=1, crc_calc=0x01FE; same frame with CRC 0x01, 0xFF -> crc_ok=0.
  - start; data 0xFF (last); CRC 0x80, 0xFF -> fmt_err=1, crc_ok=0 even though the low 15 bits match 0x00FF.
  - MAX_BYTES=4; four bytes without byte_last -> len_err=1, done pulse, crc_ok=0, byte_cnt=4, byte_ready=0 in REPORT.
  - Mid-DATA start pulse, then a clean frame 0x01/0x00/0x01 -> exactly one done pulse, crc_ok=1.
  - rst asserted in CRC_LO -> no done, all outputs at reset values; byte_valid held high through IDLE is ignored.
